vga_test_unit: RTL and testbench

//  Self-contained VGA 640x480@60 test-pattern generator for board bring-up. Produces

---
 rtl/vga_test_unit.sv | 130 +++++++++++++
 tb/tb_vga_test_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_test_unit.sv
`timescale 1ns/1ps
// vga_test_unit
//   VGA 640x480@60 test-pattern generator for board bring-up. Free-running
//   pixel/line counters drive active-low syncs and an RGB332 pixel stream;
//   switches pick the pattern (latched only at frame boundaries), LEDs echo
//   the switches.
// Ports
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous, active-high
//   sw     in   8  sw[2:0] pattern select, sw[7:3] solid colour for modes 5-7
//   hsync  out  1  horizontal sync, active low
//   vsync  out  1  vertical sync, active low
//   rgb    out  8  {R[2:0],G[2:0],B[1:0]}, 0 outside the active area
//   led    out  8  registered copy of sw
module vga_test_unit #(
  parameter int CLK_DIV = 2,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic [7:0] led
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  // Counters are at least 10 bits so the x[9:2] / x[5] pattern taps always exist.
  localparam int HW    = (H_TOT > 1024) ? $clog2(H_TOT) : 10;
  localparam int VW    = (V_TOT > 1024) ? $clog2(V_TOT) : 10;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W = H_ACT / 8;

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [7:0]    r_mode;

  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_active;
  logic          w_hs_n;
  logic          w_vs_n;
  logic [2:0]    w_bar;
  logic [7:0]    w_pix;

  // Pixel tick: with CLK_DIV=1 the divider stays at 0 and the tick is constant.
  assign w_tick   = (r_div == DW'(CLK_DIV - 1));
  assign w_h_last = (r_h == HW'(H_TOT - 1));
  assign w_v_last = (r_v == VW'(V_TOT - 1));
  assign w_active = (r_h < HW'(H_ACT)) && (r_v < VW'(V_ACT));
  assign w_hs_n   = !((r_h >= HW'(H_ACT + H_FP)) &&
                      (r_h <  HW'(H_ACT + H_FP + H_SYNC)));
  assign w_vs_n   = !((r_v >= VW'(V_ACT + V_FP)) &&
                      (r_v <  VW'(V_ACT + V_FP + V_SYNC)));
  assign w_bar    = 3'(r_h / HW'(BAR_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + VW'(1);
        end else begin
          r_h <= r_h + HW'(1);
        end
      end
    end
  end

  // Mode is captured on the same tick that wraps the counters to (0,0),
  // so the whole following frame uses one pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= '0;
    end else if (w_tick && w_h_last && w_v_last) begin
      r_mode <= sw;
    end
  end

  always_comb begin
    w_pix = '0;
    case (r_mode[2:0])
      3'd0: w_pix = '0;
      3'd1: w_pix = {{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}};
      3'd2: w_pix = (r_h[5] ^ r_v[5]) ? '1 : '0;
      3'd3: w_pix = r_h[9:2];
      3'd4: w_pix = ((r_h == '0) || (r_h == HW'(H_ACT - 1)) ||
                     (r_v == '0) || (r_v == VW'(V_ACT - 1))) ? '1 : '0;
      default: w_pix = {r_mode[7:3], r_mode[7:5]};
    endcase
  end

  // Syncs and pixel share one register stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      hsync <= w_hs_n;
      vsync <= w_vs_n;
      rgb   <= w_active ? w_pix : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
    end else begin
      led <= sw;
    end
  end

endmodule

// File: tb/tb_vga_test_unit.sv
`timescale 1ns/1ps
module tb_vga_test_unit;

  localparam int DIV    = 2;
  localparam int H_ACT  = 64;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 8;
  localparam int H_BP   = 4;
  localparam int V_ACT  = 36;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int PIX    = H_TOT * V_TOT;
  localparam int FR     = PIX * DIV;
  localparam int BAR    = H_ACT / 8;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
    logic [7:0] led;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;
  logic [7:0] led;

  int errors = 0;
  int checks = 0;
  int unsigned n = 0;          // edges since last reset edge
  logic [7:0]  mmode = 8'h00;  // model's latched frame mode
  exp_t        sbq[$];
  logic [7:0]  bar_lut [8] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};

  always #5 clk = ~clk;

  vga_test_unit #(
    .CLK_DIV(DIV),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .led(led)
  );

  function automatic logic [7:0] ref_pix(input int unsigned x, input int unsigned y,
                                         input logic [7:0] m);
    if (x >= H_ACT || y >= V_ACT) return 8'h00;
    case (m[2:0])
      3'd0: return 8'h00;
      3'd1: return bar_lut[x / BAR];
      3'd2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
      3'd3: return 8'((x / 4) % 256);
      3'd4: return (x == 0 || x == H_ACT - 1 || y == 0 || y == V_ACT - 1) ? 8'hFF : 8'h00;
      default: return {m[7:3], m[7:5]};
    endcase
  endfunction

  // Output after edge k shows the pixel whose counters were present before it.
  function automatic exp_t model_exp(input logic rst, input int unsigned k,
                                     input logic [7:0] m, input logic [7:0] s);
    exp_t e;
    int unsigned q, h, v;
    if (rst) begin
      e = '{hs: 1'b1, vs: 1'b1, rgb: 8'h00, led: 8'h00};
    end else begin
      q = (k - 1) / DIV;
      h = q % H_TOT;
      v = (q / H_TOT) % V_TOT;
      e.hs  = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC);
      e.vs  = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC);
      e.rgb = ref_pix(h, v, m);
      e.led = s;
    end
    return e;
  endfunction

  // Scoreboard producer: one expectation per clock edge.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      n = 0;
      sbq.push_back(model_exp(1'b1, 0, 8'h00, sw));
      mmode = 8'h00;
    end else begin
      n = n + 1;
      sbq.push_back(model_exp(1'b0, n, mmode, sw));
      if (n % FR == 0) mmode = sw;
    end
  end

  // Scoreboard consumer: compare on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      if (hsync !== e.hs) begin
        errors++;
        $display("FAIL sb_hsync n=%0d got=%b exp=%b", n, hsync, e.hs);
      end
      checks++;
      if (vsync !== e.vs) begin
        errors++;
        $display("FAIL sb_vsync n=%0d got=%b exp=%b", n, vsync, e.vs);
      end
      checks++;
      if (rgb !== e.rgb) begin
        errors++;
        $display("FAIL sb_rgb n=%0d got=%h exp=%h", n, rgb, e.rgb);
      end
      checks++;
      if (led !== e.led) begin
        errors++;
        $display("FAIL sb_led n=%0d got=%h exp=%h", n, led, e.led);
      end
    end
  end

  function automatic int unsigned pe(input int unsigned f, input int unsigned x,
                                     input int unsigned y);
    return (f * PIX + y * H_TOT + x) * DIV + 1;
  endfunction

  task automatic wait_n(input int unsigned target);
    int unsigned budget = 4 * FR;
    while (n < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (n != target) begin
      errors++;
      $display("FAIL wait_n got n=%0d exp n=%0d", n, target);
    end
  endtask

  task automatic test_reset();
    int unsigned k;
    int unsigned m;
    reset = 1'b1;
    sw    = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync got=%b exp=1", vsync); end
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL rst_rgb got=%h exp=00", rgb); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL rst_led got=%h exp=00", led); end
    reset = 1'b0;
    k = 0;
    while (hsync !== 1'b0 && k < 4 * FR) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != (H_ACT + H_FP) * DIV + 1) begin
      errors++;
      $display("FAIL hsync_first_fall got=%0d exp=%0d", k, (H_ACT + H_FP) * DIV + 1);
    end
    m = 0;
    while (hsync === 1'b0 && m < 4 * FR) begin
      @(negedge clk);
      m++;
    end
    checks++;
    if (m != H_SYNC * DIV) begin
      errors++;
      $display("FAIL hsync_width got=%0d exp=%0d", m, H_SYNC * DIV);
    end
  endtask

  task automatic test_line_frame();
    int unsigned n1, n2, nv, nh, nv2, lines;
    logic ph, pv;
    n1 = 0;
    n2 = 0;
    ph = hsync;
    for (int unsigned c = 0; c < 4 * H_TOT * DIV; c++) begin
      @(negedge clk);
      if (ph && !hsync) begin
        if (n1 == 0) n1 = n;
        else begin
          n2 = n;
          break;
        end
      end
      ph = hsync;
    end
    checks++;
    if (n2 - n1 != H_TOT * DIV) begin
      errors++;
      $display("FAIL line_period got=%0d exp=%0d", n2 - n1, H_TOT * DIV);
    end
    for (int unsigned c = 0; c < 2 * FR && vsync !== 1'b0; c++) @(negedge clk);
    nv = n;
    checks++;
    if (nv != (V_ACT + V_FP) * H_TOT * DIV + 1) begin
      errors++;
      $display("FAIL vsync_first_fall got=%0d exp=%0d", nv, (V_ACT + V_FP) * H_TOT * DIV + 1);
    end
    ph = hsync;
    pv = vsync;
    lines = 0;
    nh = nv;
    for (int unsigned c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      if (ph && !hsync) lines++;
      if (!pv && vsync) nh = n;
      if (pv && !vsync) break;
      ph = hsync;
      pv = vsync;
    end
    nv2 = n;
    checks++;
    if (nh - nv != V_SYNC * H_TOT * DIV) begin
      errors++;
      $display("FAIL vsync_width got=%0d exp=%0d", nh - nv, V_SYNC * H_TOT * DIV);
    end
    checks++;
    if (nv2 - nv != FR) begin
      errors++;
      $display("FAIL frame_period got=%0d exp=%0d", nv2 - nv, FR);
    end
    checks++;
    if (lines != V_TOT) begin
      errors++;
      $display("FAIL lines_per_frame got=%0d exp=%0d", lines, V_TOT);
    end
  endtask

  task automatic test_bars();
    int unsigned f;
    sw = 8'h01;
    f = n / FR + 1;
    for (int unsigned x = 0; x < H_TOT; x++) begin
      if (x < BAR || x >= H_ACT - BAR) begin
        wait_n(pe(f, x, 1));
        checks++;
        if (x >= H_ACT - BAR && x < H_ACT) begin
          if (rgb !== 8'hFF) begin errors++; $display("FAIL bar_white x=%0d got=%h exp=FF", x, rgb); end
        end else begin
          if (rgb !== 8'h00) begin errors++; $display("FAIL bar_black x=%0d got=%h exp=00", x, rgb); end
        end
      end
    end
  endtask

  task automatic test_mode_latch();
    int unsigned f;
    logic [7:0] vals [3] = '{8'h01, 8'h02, 8'h03};
    f = n / FR;
    for (int unsigned i = 0; i < 3; i++) begin
      sw = vals[i];
      @(negedge clk);
      checks++;
      if (led !== vals[i]) begin
        errors++;
        $display("FAIL led_follow got=%h exp=%h", led, vals[i]);
      end
      repeat (54) @(negedge clk);
    end
    wait_n(pe(f, H_ACT - 1, 10));
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL midframe_hold got=%h exp=FF", rgb); end
    wait_n(pe(f + 1, 4, 0));
    checks++; if (rgb !== 8'h01) begin errors++; $display("FAIL grad_x4 got=%h exp=01", rgb); end
    wait_n(pe(f + 1, 8, 0));
    checks++; if (rgb !== 8'h02) begin errors++; $display("FAIL grad_x8 got=%h exp=02", rgb); end
  endtask

  task automatic test_checker_border();
    int unsigned f;
    sw = 8'h02;
    f = n / FR + 1;
    wait_n(pe(f, 0, 0));
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL chk_0_0 got=%h exp=00", rgb); end
    wait_n(pe(f, 32, 0));
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL chk_32_0 got=%h exp=FF", rgb); end
    wait_n(pe(f, 0, 32));
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL chk_0_32 got=%h exp=FF", rgb); end
    wait_n(pe(f, 32, 32));
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL chk_32_32 got=%h exp=00", rgb); end
    sw = 8'h04;
    f = n / FR + 1;
    wait_n(pe(f, 5, 0));
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL brd_top got=%h exp=FF", rgb); end
    wait_n(pe(f, 0, 20));
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL brd_left got=%h exp=FF", rgb); end
    wait_n(pe(f, 1, 20));
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL brd_inner got=%h exp=00", rgb); end
    wait_n(pe(f, H_ACT - 1, V_ACT - 1));
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL brd_corner got=%h exp=FF", rgb); end
  endtask

  task automatic test_reset_midline();
    int unsigned k;
    for (int unsigned c = 0; c < 4 * H_TOT * DIV && hsync !== 1'b0; c++) @(negedge clk);
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync got=%b exp=0", hsync); end
    reset = 1'b1;
    sw    = 8'hFD;
    @(negedge clk);
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL mid_rst_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL mid_rst_vsync got=%b exp=1", vsync); end
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL mid_rst_rgb got=%h exp=00", rgb); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL mid_rst_led got=%h exp=00", led); end
    reset = 1'b0;
    k = 0;
    while (hsync !== 1'b0 && k < 4 * FR) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != (H_ACT + H_FP) * DIV + 1) begin
      errors++;
      $display("FAIL restart_hsync_fall got=%0d exp=%0d", k, (H_ACT + H_FP) * DIV + 1);
    end
    wait_n(pe(0, 8, 3));
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL restart_mode0 got=%h exp=00", rgb); end
    wait_n(pe(1, 8, 3));
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL restart_mode5 got=%h exp=FF", rgb); end
  endtask

  initial begin
    test_reset();
    test_line_frame();
    test_bars();
    test_mode_latch();
    test_checker_border();
    test_reset_midline();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
